// File: rtl/riscv_pipe_pkg.sv
// Shared definitions for the 5-stage RISC-V pipeline control blocks.
package riscv_pipe_pkg;

    localparam int unsigned REG_ADDR_W = 5;
    localparam logic [REG_ADDR_W-1:0] X0 = '0;

    localparam int unsigned ST_W = 1;
    localparam logic [ST_W-1:0] ST_RUN      = 1'b0;
    localparam logic [ST_W-1:0] ST_MEM_WAIT = 1'b1;

    // True when an ID source operand depends on the register an EX-stage instruction writes.
    function automatic logic src_dep(input logic use_src,
                                     input logic [REG_ADDR_W-1:0] src,
                                     input logic [REG_ADDR_W-1:0] dst);
        return use_src && (src == dst);
    endfunction

endpackage

// File: rtl/pipeline_hazard_controller_sat_counter.sv
// Saturating up-counter with synchronous clear and asynchronous active-low reset.
module sat_counter #(
    parameter int unsigned W   = 8,
    parameter logic [W-1:0] MAX = '1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    input  logic         clear,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc && (count != MAX)) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Load-use / redirect / memory-wait hazard sequencer with stall and flush statistics.
module pipeline_hazard_controller
    import riscv_pipe_pkg::*;
#(
    parameter int unsigned CNT_W   = 32,
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned TO_W    = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [REG_ADDR_W-1:0] id_rs1_i,
    input  logic [REG_ADDR_W-1:0] id_rs2_i,
    input  logic                  id_use_rs1_i,
    input  logic                  id_use_rs2_i,
    input  logic [REG_ADDR_W-1:0] ex_rd_i,
    input  logic                  ex_memread_i,
    input  logic                  ex_redirect_i,
    input  logic                  mem_req_i,
    input  logic                  mem_ready_i,
    output logic                  pc_write_o,
    output logic                  ifid_write_o,
    output logic                  ifid_flush_o,
    output logic                  ctrl_bubble_o,
    output logic                  pipe_hold_o,
    output logic [CNT_W-1:0]      stall_cnt_o,
    output logic [CNT_W-1:0]      flush_cnt_o,
    output logic                  mem_timeout_o
);

    logic [ST_W-1:0] state;
    logic [ST_W-1:0] state_nxt;
    logic            load_use;
    logic            mem_stall;
    logic            redirect_take;
    logic            wait_clr;
    logic [TO_W-1:0] wait_cnt;

    // Decode is forced to RUN defaults while reset is held low.
    assign mem_stall = reset && mem_req_i && !mem_ready_i;
    assign load_use  = reset && ex_memread_i && (ex_rd_i != X0) &&
                       (src_dep(id_use_rs1_i, id_rs1_i, ex_rd_i) ||
                        src_dep(id_use_rs2_i, id_rs2_i, ex_rd_i));
    assign redirect_take = reset && ex_redirect_i && !mem_stall;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_RUN;
        end else begin
            state <= state_nxt;
        end
    end

    // Release from MEM_WAIT uses the RUN decode in the same cycle, so state only steers the wait counter.
    always_comb begin
        state_nxt     = state;
        pc_write_o    = 1'b1;
        ifid_write_o  = 1'b1;
        ifid_flush_o  = 1'b0;
        ctrl_bubble_o = 1'b0;
        pipe_hold_o   = 1'b0;
        if (mem_stall) begin
            state_nxt    = ST_MEM_WAIT;
            pc_write_o   = 1'b0;
            ifid_write_o = 1'b0;
            pipe_hold_o  = 1'b1;
        end else begin
            state_nxt = ST_RUN;
            if (redirect_take) begin
                ifid_flush_o  = 1'b1;
                ctrl_bubble_o = 1'b1;
            end else if (load_use) begin
                pc_write_o    = 1'b0;
                ifid_write_o  = 1'b0;
                ctrl_bubble_o = 1'b1;
            end
        end
    end

    assign wait_clr = !mem_stall && (state == ST_MEM_WAIT);

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (!pc_write_o),
        .clear (1'b0),
        .count (stall_cnt_o)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (redirect_take),
        .clear (1'b0),
        .count (flush_cnt_o)
    );

    sat_counter #(.W(TO_W), .MAX(TO_W'(TIMEOUT))) u_wait_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (mem_stall),
        .clear (wait_clr),
        .count (wait_cnt)
    );

    // Flag rises on the same edge at which the wait count reaches TIMEOUT.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_timeout_o <= 1'b0;
        end else if (mem_stall && (wait_cnt >= TO_W'(TIMEOUT - 1))) begin
            mem_timeout_o <= 1'b1;
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Directed bench for pipeline_hazard_controller (TIMEOUT=4).
module tb_pipeline_hazard_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  id_rs1, id_rs2, ex_rd;
    logic        use1, use2, ex_memread, ex_redirect, mem_req, mem_ready;
    logic        pc_write, ifid_write, ifid_flush, ctrl_bubble, pipe_hold, mem_timeout;
    logic [31:0] stall_cnt, flush_cnt;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    pipeline_hazard_controller #(.CNT_W(32), .TIMEOUT(4), .TO_W(8)) dut (
        .clk           (clk),
        .reset         (reset),
        .id_rs1_i      (id_rs1),
        .id_rs2_i      (id_rs2),
        .id_use_rs1_i  (use1),
        .id_use_rs2_i  (use2),
        .ex_rd_i       (ex_rd),
        .ex_memread_i  (ex_memread),
        .ex_redirect_i (ex_redirect),
        .mem_req_i     (mem_req),
        .mem_ready_i   (mem_ready),
        .pc_write_o    (pc_write),
        .ifid_write_o  (ifid_write),
        .ifid_flush_o  (ifid_flush),
        .ctrl_bubble_o (ctrl_bubble),
        .pipe_hold_o   (pipe_hold),
        .stall_cnt_o   (stall_cnt),
        .flush_cnt_o   (flush_cnt),
        .mem_timeout_o (mem_timeout)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Compare {pc_write, ifid_write, ifid_flush, ctrl_bubble, pipe_hold}.
    task automatic check_ctl(input string tag, input logic [4:0] exp);
        check(tag, {27'd0, pc_write, ifid_write, ifid_flush, ctrl_bubble, pipe_hold}, {27'd0, exp});
    endtask

    task automatic idle_inputs();
        id_rs1 = 5'd0; id_rs2 = 5'd0; ex_rd = 5'd0;
        use1 = 1'b0; use2 = 1'b0; ex_memread = 1'b0; ex_redirect = 1'b0;
        mem_req = 1'b0; mem_ready = 1'b0;
    endtask

    // Advance through one rising edge, leaving time 1 unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        idle_inputs();
        reset = 1'b0;
        #12;
        check_ctl("reset_ctl", 5'b11000);
        check("reset_stall_cnt", stall_cnt, 32'd0);
        check("reset_flush_cnt", flush_cnt, 32'd0);
        check("reset_timeout", {31'd0, mem_timeout}, 32'd0);
        reset = 1'b1;
        tick();

        // 1: lw x5 in EX, add x6,x5,x7 in ID
        ex_memread = 1'b1; ex_rd = 5'd5;
        id_rs1 = 5'd5; use1 = 1'b1; id_rs2 = 5'd7; use2 = 1'b1;
        #1 check_ctl("load_use_rs1", 5'b00010);
        tick();
        check("load_use_stall_cnt", stall_cnt, 32'd1);
        id_rs1 = 5'd7; id_rs2 = 5'd5;
        #1 check_ctl("load_use_rs2", 5'b00010);
        tick();
        check("load_use_rs2_stall_cnt", stall_cnt, 32'd2);

        // 2: loads to x0 and unused source operands never stall
        ex_rd = 5'd0; id_rs1 = 5'd0; id_rs2 = 5'd0;
        #1 check_ctl("lw_x0_no_stall", 5'b11000);
        tick();
        ex_rd = 5'd5; id_rs1 = 5'd3; use1 = 1'b0; id_rs2 = 5'd5; use2 = 1'b0;
        #1 check_ctl("unused_rs2_no_stall", 5'b11000);
        tick();
        check("no_stall_cnt", stall_cnt, 32'd2);

        // 3: redirect outranks load-use
        id_rs1 = 5'd5; use1 = 1'b1; ex_redirect = 1'b1;
        #1 check_ctl("redirect_over_load_use", 5'b11110);
        tick();
        check("redirect_flush_cnt", flush_cnt, 32'd1);
        check("redirect_stall_cnt", stall_cnt, 32'd2);

        // 4: three wait cycles then release; redirect during the wait is ignored
        idle_inputs();
        mem_req = 1'b1; mem_ready = 1'b0; ex_redirect = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1 check_ctl("mem_wait_hold", 5'b00001);
            tick();
        end
        check("mem_wait_flush_cnt", flush_cnt, 32'd1);
        check("mem_wait_stall_cnt", stall_cnt, 32'd5);
        check("mem_wait_no_timeout", {31'd0, mem_timeout}, 32'd0);
        ex_redirect = 1'b0; mem_ready = 1'b1;
        #1 check_ctl("mem_release", 5'b11000);
        tick();
        check("mem_release_stall_cnt", stall_cnt, 32'd5);

        // 5: ready low for six cycles against TIMEOUT=4
        mem_ready = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            tick();
            check($sformatf("timeout_wait%0d", i), {31'd0, mem_timeout}, (i >= 4) ? 32'd1 : 32'd0);
        end
        check("timeout_stall_cnt", stall_cnt, 32'd11);

        // 6: asynchronous reset while still waiting on memory
        #2 reset = 1'b0;
        #1;
        check_ctl("reset_mid_wait_ctl", 5'b11000);
        check("reset_mid_wait_stall_cnt", stall_cnt, 32'd0);
        check("reset_mid_wait_timeout", {31'd0, mem_timeout}, 32'd0);
        idle_inputs();
        reset = 1'b1;
        tick();
        check_ctl("post_reset_run", 5'b11000);
        check("post_reset_stall_cnt", stall_cnt, 32'd0);
        check("post_reset_flush_cnt", flush_cnt, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
